// File: rtl/xb_mux_pkg.sv
// Shared types and header layout for the Xillybus read-stream merger.
package xb_mux_pkg;

  localparam logic [7:0]  HDR_MAGIC     = 8'hA5;
  localparam int unsigned HDR_MAGIC_LSB = 24;
  localparam int unsigned HDR_CH_LSB    = 16;
  localparam int unsigned HDR_SEQ_LSB   = 0;

  typedef enum logic [1:0] {IDLE, HDR, DATA, EOF} state_t;

  function automatic logic [31:0] make_hdr(input logic [7:0] ch, input logic [15:0] seq);
    logic [31:0] h;
    h = '0;
    h[HDR_MAGIC_LSB +: 8] = HDR_MAGIC;
    h[HDR_CH_LSB +: 8]    = ch;
    h[HDR_SEQ_LSB +: 16]  = seq;
    return h;
  endfunction

endpackage

// File: rtl/xb_sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count and synchronous flush.
module xb_sync_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/xb_rd_stream_mux.sv
// N-channel frame merger onto one Xillybus read stream with per-frame headers.
// Define XB_MUX_STATS_EN to add the per-channel ch_frames counters.
module xb_rd_stream_mux
  import xb_mux_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 512,
  parameter int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  bus_clk,
  input  logic                  trn_reset_n,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH-1:0]       in_last,
  output logic [N_CH-1:0]       in_ready,
  input  logic [N_CH-1:0]       ch_enable,
  input  logic                  eof_req,
  input  logic                  user_r_rd_open,
  input  logic                  user_r_rd_rden,
  output logic [WIDTH-1:0]      user_r_rd_data,
  output logic                  user_r_rd_empty,
  output logic                  user_r_rd_eof,
  output logic [N_CH-1:0]       ch_overflow
`ifdef XB_MUX_STATS_EN
  ,
  output logic [N_CH*16-1:0]    ch_frames
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic              is_open, open_d, open_rise, fire;
  logic [N_CH-1:0]   synced, push, pop, f_full, f_empty;
  logic [WIDTH:0]    f_dout [N_CH];
  logic [AW:0]       f_cnt  [N_CH];
  logic [WIDTH:0]    cur_word;
  logic [WIDTH-1:0]  hdr_word;

  state_t            state;
  logic [CH_W-1:0]   cur, ptr, sel, cur_next;
  logic [15:0]       seq [N_CH];
  logic              eof_pend, found;
  int unsigned       idx;

  assign is_open   = user_r_rd_open;
  assign open_rise = is_open && !open_d;
  assign cur_word  = f_dout[cur];
  assign cur_next  = (cur == CH_W'(N_CH-1)) ? '0 : cur + 1'b1;
  assign fire      = user_r_rd_rden && !user_r_rd_empty;
  assign user_r_rd_eof = (state == EOF);

  always_comb begin
    user_r_rd_empty = 1'b1;
    case (state)
      HDR:     user_r_rd_empty = !is_open;
      DATA:    user_r_rd_empty = !is_open || f_empty[cur];
      default: user_r_rd_empty = 1'b1;
    endcase
  end

  // Words are accepted even while unsynced or closed; they are simply not stored.
  always_comb begin
    in_ready = '0;
    push     = '0;
    pop      = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      in_ready[k] = trn_reset_n && (!is_open || !f_full[k]);
      push[k]     = is_open && synced[k] && in_valid[k] && !f_full[k];
      pop[k]      = fire && (state == DATA) && (cur == CH_W'(k));
    end
  end

  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      idx = (32'(ptr) + i) % N_CH;
      if (!found && ch_enable[idx] && (f_cnt[idx] != '0)) begin
        found = 1'b1;
        sel   = CH_W'(idx);
      end
    end
  end

  always_comb begin
    hdr_word       = '0;
    hdr_word[31:0] = make_hdr(8'(cur), seq[cur]);
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_fifo
    xb_sync_fifo #(.WIDTH(WIDTH+1), .DEPTH(DEPTH)) u_fifo (
      .clk   (bus_clk),
      .rst_n (trn_reset_n),
      .flush (!is_open),
      .push  (push[k]),
      .din   ({in_last[k], in_data[k*WIDTH +: WIDTH]}),
      .pop   (pop[k]),
      .dout  (f_dout[k]),
      .full  (f_full[k]),
      .empty (f_empty[k]),
      .count (f_cnt[k])
    );
  end

  always_ff @(posedge bus_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      open_d      <= 1'b0;
      synced      <= '0;
      ch_overflow <= '0;
    end else begin
      open_d      <= is_open;
      ch_overflow <= (open_rise ? '0 : ch_overflow) | (is_open ? (in_valid & ~in_ready) : '0);
      for (int unsigned k = 0; k < N_CH; k++) begin
        if (!is_open)
          synced[k] <= 1'b0;
        else if (in_valid[k] && in_ready[k] && in_last[k])
          synced[k] <= 1'b1;
      end
    end
  end

  always_ff @(posedge bus_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      state          <= IDLE;
      cur            <= '0;
      ptr            <= '0;
      eof_pend       <= 1'b0;
      user_r_rd_data <= '0;
      for (int unsigned k = 0; k < N_CH; k++) seq[k] <= '0;
    end else if (!is_open) begin
      state    <= IDLE;
      eof_pend <= 1'b0;
      for (int unsigned k = 0; k < N_CH; k++) seq[k] <= '0;
    end else begin
      if (eof_req) eof_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (found) begin
            cur   <= sel;
            state <= HDR;
          end else if (eof_pend) begin
            state <= EOF;
          end
        end
        HDR: begin
          if (user_r_rd_rden) begin
            user_r_rd_data <= hdr_word;
            seq[cur]       <= seq[cur] + 1'b1;
            state          <= DATA;
          end
        end
        DATA: begin
          if (fire) begin
            user_r_rd_data <= cur_word[WIDTH-1:0];
            if (cur_word[WIDTH]) begin
              ptr   <= cur_next;
              state <= IDLE;
            end
          end
        end
        default: state <= EOF;
      endcase
    end
  end

`ifdef XB_MUX_STATS_EN
  always_ff @(posedge bus_clk or negedge trn_reset_n) begin
    if (!trn_reset_n)
      ch_frames <= '0;
    else if (open_rise)
      ch_frames <= '0;
    else if (fire && (state == DATA) && cur_word[WIDTH])
      ch_frames[32'(cur)*16 +: 16] <= ch_frames[32'(cur)*16 +: 16] + 16'd1;
  end
`endif

endmodule

// File: tb/tb_xb_rd_stream_mux.sv
// Directed + randomized bench for xb_rd_stream_mux against a frame-level reference model.
module tb_xb_rd_stream_mux;

  localparam int N = 4;
  localparam int W = 32;
  localparam int D = 16;

  logic             bus_clk = 1'b0;
  logic             trn_reset_n;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_valid, in_last, in_ready, ch_enable, ch_overflow;
  logic             eof_req, user_r_rd_open, user_r_rd_rden;
  logic [W-1:0]     user_r_rd_data;
  logic             user_r_rd_empty, user_r_rd_eof;

  xb_rd_stream_mux #(.N_CH(N), .WIDTH(W), .DEPTH(D)) dut (
    .bus_clk         (bus_clk),
    .trn_reset_n     (trn_reset_n),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_last         (in_last),
    .in_ready        (in_ready),
    .ch_enable       (ch_enable),
    .eof_req         (eof_req),
    .user_r_rd_open  (user_r_rd_open),
    .user_r_rd_rden  (user_r_rd_rden),
    .user_r_rd_data  (user_r_rd_data),
    .user_r_rd_empty (user_r_rd_empty),
    .user_r_rd_eof   (user_r_rd_eof),
    .ch_overflow     (ch_overflow)
  );

  always #5 bus_clk = ~bus_clk;

  // Reference model: stored whole frames per channel, sync flags, header sequence numbers.
  logic [32:0]  mq [N][$];
  bit           msync [N];
  logic [15:0]  mseq [N];
  int unsigned  mptr;
  logic [31:0]  exp_q [$];
  int           n_cmp = 0;
  int           n_err = 0;

  task automatic tick();
    @(posedge bus_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, expv);
    end
  endtask

  task automatic model_close();
    for (int k = 0; k < N; k++) begin
      mq[k].delete();
      msync[k] = 0;
      mseq[k]  = '0;
    end
    exp_q.delete();
  endtask

  task automatic push_word(input int ch, input logic [31:0] d, input logic l);
    logic rdy;
    in_data[ch*W +: W] = d;
    in_last[ch]  = l;
    in_valid[ch] = 1'b1;
    rdy = !user_r_rd_open || (mq[ch].size() < D);
    check($sformatf("in_ready%0d", ch), 32'(in_ready[ch]), 32'(rdy));
    tick();
    in_valid[ch] = 1'b0;
    in_last[ch]  = 1'b0;
    if (!user_r_rd_open) msync[ch] = 0;
    else if (rdy) begin
      if (msync[ch]) mq[ch].push_back({l, d});
      else if (l) msync[ch] = 1;
    end
  endtask

  task automatic push_frame(input int ch, input int len);
    for (int i = 0; i < len; i++) push_word(ch, $urandom, (i == len-1));
  endtask

  // Round-robin over whole frames, starting after the last channel served.
  task automatic model_arb();
    int c;
    logic [32:0] w;
    forever begin
      c = -1;
      for (int i = 0; i < N; i++) begin
        int k;
        k = (int'(mptr) + i) % N;
        if (c < 0 && ch_enable[k] && mq[k].size() > 0) c = k;
      end
      if (c < 0) break;
      exp_q.push_back({8'hA5, 8'(c), mseq[c]});
      mseq[c]++;
      do begin
        w = mq[c].pop_front();
        exp_q.push_back(w[31:0]);
      end while (!w[32] && mq[c].size() > 0);
      mptr = (c + 1) % N;
    end
  endtask

  task automatic drain(input int n, input logic [3:0] mask, input string tag);
    int got, cyc;
    logic fire;
    ch_enable = mask;
    model_arb();
    got = 0;
    cyc = 0;
    while (exp_q.size() > 0 && (n == 0 || got < n) && cyc < 4000) begin
      user_r_rd_rden = ($urandom_range(0, 3) != 0);
      fire = user_r_rd_rden && (user_r_rd_empty === 1'b0);
      tick();
      cyc++;
      if (fire) begin
        check(tag, user_r_rd_data, exp_q.pop_front());
        check({tag, "_eof"}, 32'(user_r_rd_eof), 32'd0);
        got++;
      end
    end
    user_r_rd_rden = 1'b0;
    check({tag, "_left"}, (n == 0) ? 32'(exp_q.size()) : 32'(n - got), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    trn_reset_n = 1'b0; in_data = '0; in_valid = '0; in_last = '0; ch_enable = '0;
    eof_req = 1'b0; user_r_rd_open = 1'b0; user_r_rd_rden = 1'b0;
    model_close();
    mptr = 0;
    tick(); tick();
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_data", user_r_rd_data, 32'd0);
    check("rst_empty", 32'(user_r_rd_empty), 32'd1);
    check("rst_eof", 32'(user_r_rd_eof), 32'd0);
    check("rst_ovf", 32'(ch_overflow), 32'd0);
    trn_reset_n = 1'b1;
    tick();

    user_r_rd_open = 1'b1;
    tick();
    for (int k = 0; k < N; k++) push_word(k, 32'h5A5A_0000 + k, 1'b1);

    // Single frame on channel 2
    for (int i = 0; i < 3; i++) push_word(2, 32'hD000_0000 + i, (i == 2));
    drain(0, 4'hF, "ch2_frame");
    tick(); tick();
    check("ch2_empty", 32'(user_r_rd_empty), 32'd1);

    // Two frames each on channels 0 and 1
    ch_enable = '0;
    push_frame(0, $urandom_range(1, 3));
    push_frame(0, $urandom_range(1, 3));
    push_frame(1, $urandom_range(1, 3));
    push_frame(1, $urandom_range(1, 3));
    drain(0, 4'hF, "rr_2x2");

    // Randomized rounds with random enable masks
    for (int r = 0; r < 6; r++) begin
      ch_enable = '0;
      for (int k = 0; k < N; k++) begin
        int nf;
        nf = $urandom_range(0, 2);
        for (int f = 0; f < nf; f++) begin
          int len;
          len = $urandom_range(1, 4);
          if (mq[k].size() + len <= D) push_frame(k, len);
        end
      end
      drain(0, 4'($urandom_range(1, 15)), "rand_round");
    end
    drain(0, 4'hF, "rand_flush");

    // Overflow on channel 0
    ch_enable = '0;
    for (int i = 0; i <= D; i++) push_word(0, 32'hF000_0000 + i, (i == D-1));
    check("ovf_set", 32'(ch_overflow), 32'h1);
    drain(2, 4'hF, "ovf_head");
    check("ovf_ready_back", 32'(in_ready[0]), 32'd1);
    drain(0, 4'hF, "ovf_rest");

    // Close, channel 3 mid-frame across the reopen
    user_r_rd_open = 1'b0;
    tick(); tick();
    model_close();
    check("closed_empty", 32'(user_r_rd_empty), 32'd1);
    check("closed_ready", 32'(in_ready), 32'hF);
    check("closed_ovf_sticky", 32'(ch_overflow), 32'h1);
    ch_enable = '0;
    for (int i = 0; i < 3; i++) push_word(3, 32'hC000_0000 + i, 1'b0);
    user_r_rd_open = 1'b1;
    tick();
    check("reopen_ovf_clr", 32'(ch_overflow), 32'd0);
    for (int i = 0; i < 5; i++) push_word(3, 32'hC100_0000 + i, (i == 4));
    push_frame(3, 2);
    drain(0, 4'hF, "resync_ch3");
    for (int k = 0; k < 3; k++) push_word(k, 32'h5A5A_1000 + k, 1'b1);

    // EOF requested mid-frame on channel 1
    ch_enable = '0;
    push_frame(1, 4);
    drain(2, 4'hF, "eof_pre");
    ch_enable = '0;
    eof_req = 1'b1;
    tick();
    eof_req = 1'b0;
    push_frame(0, 1);
    drain(0, 4'hF, "eof_drain");
    tick(); tick(); tick();
    check("eof_flag", 32'(user_r_rd_eof), 32'd1);
    check("eof_empty", 32'(user_r_rd_empty), 32'd1);
    user_r_rd_rden = 1'b1;
    tick();
    user_r_rd_rden = 1'b0;
    check("eof_hold", 32'(user_r_rd_eof), 32'd1);
    user_r_rd_open = 1'b0;
    tick();
    model_close();
    check("eof_close", 32'(user_r_rd_eof), 32'd0);
    user_r_rd_open = 1'b1;
    tick(); tick(); tick();
    check("reopen_empty", 32'(user_r_rd_empty), 32'd1);
    check("reopen_eof", 32'(user_r_rd_eof), 32'd0);

    // Asynchronous reset with FIFOs half full and a frame in progress
    for (int k = 0; k < N; k++) push_word(k, 32'h5A5A_2000 + k, 1'b1);
    ch_enable = '0;
    for (int k = 0; k < N; k++) push_frame(k, D/2);
    drain(3, 4'hF, "pre_reset");
    #3;
    trn_reset_n = 1'b0;
    #1;
    check("arst_data", user_r_rd_data, 32'd0);
    check("arst_empty", 32'(user_r_rd_empty), 32'd1);
    check("arst_eof", 32'(user_r_rd_eof), 32'd0);
    check("arst_ready", 32'(in_ready), 32'd0);
    check("arst_ovf", 32'(ch_overflow), 32'd0);
    model_close();
    mptr = 0;
    #2;
    trn_reset_n = 1'b1;
    user_r_rd_rden = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    user_r_rd_rden = 1'b0;
    check("post_rst_empty", 32'(user_r_rd_empty), 32'd1);
    check("post_rst_nohdr", user_r_rd_data, 32'd0);
    push_word(1, 32'h5A5A_3001, 1'b1);
    ch_enable = '0;
    push_frame(1, 3);
    drain(0, 4'hF, "post_rst_frame");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
